// File: rtl/moore_pattern_detector.sv
// moore_pattern_detector
//   Moore serial pattern detector with a runtime-loadable PAT_W-bit pattern,
//   overlap / non-overlap restart, an input-qualifying enable and a
//   saturating match counter. y is the registered match flag.
//   Optional feature: define MOORE_DET_MASK_EN to add pat_mask_in and a
//   per-bit don't-care mask (mask bit 1 = bit ignored in the compare).
module moore_pattern_detector #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1101
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef MOORE_DET_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in,
`endif
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // fill_q counts 0..PAT_W, so it needs enough bits to hold PAT_W itself
  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic [PAT_W-1:0]  hist_q,  hist_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
`ifdef MOORE_DET_MASK_EN
  logic [PAT_W-1:0]  mask_q,  mask_d;
`endif

  // candidate history / fill / match if the current bit is accepted
  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_n;
  logic              match_n;
  logic [PAT_W-1:0]  bit_ok;

  // the oldest history bit is shifted out without being read
  logic unused_hist_msb;
  assign unused_hist_msb = hist_q[PAT_W-1];

  // Shift in the new bit; after a match in non-overlap mode the history
  // restarts from this bit alone so the previous match bits are not reused.
  always_comb begin
    hist_n = hist_q;
    fill_n = fill_q;
    if (overlap || !match_q) begin
      hist_n = {hist_q[PAT_W-2:0], x};
      fill_n = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    end else begin
      hist_n = {{(PAT_W-1){1'b0}}, x};
      fill_n = FILL_W'(1);
    end
  end

  // per-bit compare of the candidate history against the loaded pattern
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
`ifdef MOORE_DET_MASK_EN
    assign bit_ok[gi] = mask_q[gi] | (hist_n[gi] ~^ pat_q[gi]);
`else
    assign bit_ok[gi] = hist_n[gi] ~^ pat_q[gi];
`endif
  end

  assign match_n = (fill_n == FILL_FULL) && (&bit_ok);

  // Next-state selection: pattern load beats enable; clear beats increment.
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    cnt_d   = cnt_q;
`ifdef MOORE_DET_MASK_EN
    mask_d  = mask_q;
`endif
    if (pat_load) begin
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      match_d = 1'b0;
`ifdef MOORE_DET_MASK_EN
      mask_d  = pat_mask_in;
`endif
    end else if (en) begin
      hist_d  = hist_n;
      fill_d  = fill_n;
      match_d = match_n;
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (!pat_load && en && match_n && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pat_q   <= PAT_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
`ifdef MOORE_DET_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
`ifdef MOORE_DET_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign y         = match_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_moore_pattern_detector.sv
// tb_moore_pattern_detector
//   Directed-vector bench. Two instances share the stimulus: dut8 (CNT_W=8)
//   carries the functional checks, dut2 (CNT_W=2) the counter saturation.
module tb_moore_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       cnt_clr = 1'b0;

  logic       y8, sat8, y2, sat2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  moore_pattern_detector #(.PAT_W(4), .CNT_W(8), .PAT_RST(4'b1101)) dut8 (
    .clk(clk), .rst_b(rst_b), .en(en), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .y(y8), .match_cnt(cnt8), .cnt_sat(sat8)
  );

  moore_pattern_detector #(.PAT_W(4), .CNT_W(2), .PAT_RST(4'b1101)) dut2 (
    .clk(clk), .rst_b(rst_b), .en(en), .x(x), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .y(y2), .match_cnt(cnt2), .cnt_sat(sat2)
  );

  // single comparison point: counts and reports every check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  // one clock cycle of stimulus; returns 1 time unit after the rising edge
  task automatic cyc(input logic e, input logic b, input logic pl, input logic clr);
    en = e; x = b; pat_load = pl; cnt_clr = clr;
    @(posedge clk);
    #1;
    en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
  endtask

  // accept n bits (MSB first) and check y after each edge
  task automatic stream(input string name, input logic [6:0] bits, input int n, input logic [6:0] yexp);
    for (int i = n - 1; i >= 0; i--) begin
      cyc(1'b1, bits[i], 1'b0, 1'b0);
      check_eq($sformatf("%s y after bit %0d", name, n - i), {31'b0, y8}, {31'b0, yexp[i]});
    end
  endtask

  // assert reset between edges, check outputs at once, release between edges
  task automatic do_reset(input string name);
    #2 rst_b = 1'b0;
    #1;
    check_eq($sformatf("%s y", name), {31'b0, y8}, 32'd0);
    check_eq($sformatf("%s cnt", name), {24'b0, cnt8}, 32'd0);
    check_eq($sformatf("%s cnt2", name), {30'b0, cnt2}, 32'd0);
    @(posedge clk);
    #3 rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // power-on reset
    @(posedge clk); @(posedge clk);
    #3 rst_b = 1'b1;
    @(posedge clk); #1;
    check_eq("reset y", {31'b0, y8}, 32'd0);
    check_eq("reset cnt", {24'b0, cnt8}, 32'd0);
    check_eq("reset sat", {31'b0, sat8}, 32'd0);

    // basic detection of 1101
    overlap = 1'b1;
    stream("basic", 7'b0001101, 4, 7'b0000001);
    check_eq("basic cnt", {24'b0, cnt8}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("basic y drop", {31'b0, y8}, 32'd0);

    // overlapping stream 1101101
    do_reset("rst ovl");
    overlap = 1'b1;
    stream("ovl", 7'b1101101, 7, 7'b0001001);
    check_eq("ovl cnt", {24'b0, cnt8}, 32'd2);

    // same stream, non-overlapping
    do_reset("rst novl");
    overlap = 1'b0;
    stream("novl", 7'b1101101, 7, 7'b0001000);
    check_eq("novl cnt", {24'b0, cnt8}, 32'd1);

    // enable gaps do not disturb history
    do_reset("rst gap");
    overlap = 1'b1;
    stream("gap pre", 7'b0000011, 2, 7'b0000000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq($sformatf("gap idle %0d y", i), {31'b0, y8}, 32'd0);
    end
    stream("gap post", 7'b0000001, 2, 7'b0000001);
    check_eq("gap cnt", {24'b0, cnt8}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq($sformatf("gap hold %0d y", i), {31'b0, y8}, 32'd1);
    end

    // reload with 0110: history flushed, counter kept
    stream("rl pre", 7'b0000110, 3, 7'b0000000);
    pat_in = 4'b0110;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("rl load y", {31'b0, y8}, 32'd0);
    check_eq("rl load cnt", {24'b0, cnt8}, 32'd1);
    stream("rl flush", 7'b0000001, 1, 7'b0000000);
    stream("rl new", 7'b0000110, 4, 7'b0000001);
    check_eq("rl cnt", {24'b0, cnt8}, 32'd2);

    // async reset while y=1 restores PAT_RST
    do_reset("async");
    overlap = 1'b1;
    stream("post rst", 7'b0001101, 4, 7'b0000001);
    check_eq("post rst cnt", {24'b0, cnt8}, 32'd1);

    // saturation on the 2-bit counter
    do_reset("rst sat");
    overlap = 1'b1;
    for (int m = 1; m <= 5; m++) begin
      stream($sformatf("sat m%0d", m), 7'b0001101, 4, 7'b0000001);
      check_eq($sformatf("sat m%0d cnt2", m), {30'b0, cnt2}, (m >= 3) ? 32'd3 : 32'(m));
      check_eq($sformatf("sat m%0d sat2", m), {31'b0, sat2}, (m >= 3) ? 32'd1 : 32'd0);
      check_eq($sformatf("sat m%0d cnt8", m), {24'b0, cnt8}, 32'(m));
    end
    check_eq("sat8 low", {31'b0, sat8}, 32'd0);

    // clear on the same edge as a match: match is not counted
    stream("clr pre", 7'b0000110, 3, 7'b0000000);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("clr y", {31'b0, y8}, 32'd1);
    check_eq("clr cnt8", {24'b0, cnt8}, 32'd0);
    check_eq("clr cnt2", {30'b0, cnt2}, 32'd0);
    check_eq("clr sat2", {31'b0, sat2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
